// File: rtl/phys_reg_wb_arbiter_pkg.sv
// Shared constants and types for the physical-register writeback arbiter.
package phys_reg_wb_arbiter_pkg;

  localparam int unsigned DEF_NUM_REQ       = 3;
  localparam int unsigned DEF_NUM_PHYS_REGS = 64;

  localparam logic BUSY_SET = 1'b1;
  localparam logic BUSY_CLR = 1'b0;

  // Source that drives the busy-list port in a given cycle
  typedef enum logic [1:0] {
    BSRC_NONE,
    BSRC_ALLOC,
    BSRC_PEND,
    BSRC_DIRECT
  } busy_src_e;

  // Physical register index width (LOG_PHYS), at least one bit
  function automatic int unsigned log_phys(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// NUM_REQ-wide round-robin arbiter: combinational one-hot grant, registered search pointer.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] sel;
  logic             found;

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    sel   = '0;
    if (!reset && en) begin
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
        sel = PTR_W'((32'(ptr_q) + off) % NUM_REQ);
        if (!found && req[sel]) begin
          found      = 1'b1;
          grant[sel] = 1'b1;
          ptr_d      = PTR_W'((32'(sel) + 1) % NUM_REQ);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/phys_reg_wb_arbiter.sv
// Shares the register-file write port and busy-list port between writeback units and rename.
// Optional per-requester stall counters: define WB_ARB_STALL_CNT_EN.
module phys_reg_wb_arbiter
  import phys_reg_wb_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_PHYS_REGS = DEF_NUM_PHYS_REGS,
  parameter  int unsigned NUM_REQ       = DEF_NUM_REQ,
  parameter  int unsigned PEND_DEPTH    = 2,
  localparam int unsigned LOG_PHYS      = log_phys(NUM_PHYS_REGS)
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [NUM_REQ-1:0]           Req_IN,
  input  logic [NUM_REQ*LOG_PHYS-1:0]  ReqReg_IN,
  input  logic [NUM_REQ*32-1:0]        ReqData_IN,
  output logic [NUM_REQ-1:0]           Grant_OUT,
  input  logic                         Alloc_IN,
  input  logic [LOG_PHYS-1:0]          AllocReg_IN,
  output logic [LOG_PHYS-1:0]          RegWrite_OUT,
  output logic [31:0]                  DataWrite_OUT,
  output logic                         Write_OUT,
  output logic [LOG_PHYS-1:0]          BusyReg_OUT,
  output logic                         SetBusy_OUT,
  output logic                         BusyValue_OUT
`ifdef WB_ARB_STALL_CNT_EN
  ,output logic [NUM_REQ*16-1:0]       StallCnt_OUT
`endif
);

  localparam int unsigned PW = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
  localparam int unsigned CW = $clog2(PEND_DEPTH + 1);

  logic [NUM_REQ-1:0]  grant;
  logic                arb_en, wb_fire;
  logic [LOG_PHYS-1:0] wb_reg;
  logic [31:0]         wb_data;

  logic [LOG_PHYS-1:0] pend_reg_q [PEND_DEPTH];
  logic [LOG_PHYS-1:0] pend_reg_d [PEND_DEPTH];
  logic [PEND_DEPTH-1:0] pend_vld_q, pend_vld_d;
  logic [PW-1:0]       head_q, head_d, tail_q, tail_d, scan_idx, hit_idx;
  logic [CW-1:0]       cnt_q, cnt_d, pops, pop_n;
  logic                pend_full, pend_hit, enq;
  busy_src_e           busy_src;

  logic                write_q, write_d, set_busy_q, set_busy_d, busy_val_q, busy_val_d;
  logic [LOG_PHYS-1:0] reg_wr_q, reg_wr_d, busy_reg_q, busy_reg_d;
  logic [31:0]         data_wr_q, data_wr_d;

  // A granted clear must always find a slot: block grants only when nothing can dequeue
  assign pend_full = (cnt_q == CW'(PEND_DEPTH));
  assign arb_en    = !(pend_full && Alloc_IN);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .clk   (CLK),
    .reset (RESET),
    .req   (Req_IN),
    .en    (arb_en),
    .grant (grant)
  );

  assign Grant_OUT = grant;
  assign wb_fire   = |grant;

  always_comb begin
    wb_reg  = '0;
    wb_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        wb_reg  = ReqReg_IN[i*LOG_PHYS +: LOG_PHYS];
        wb_data = ReqData_IN[i*32 +: 32];
      end
    end
  end

  // Oldest still-valid queued clear; invalidated entries ahead of it are popped with it
  always_comb begin
    pend_hit = 1'b0;
    hit_idx  = '0;
    pops     = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < PEND_DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if (!pend_hit && (i < 32'(cnt_q)) && pend_vld_q[scan_idx]) begin
        pend_hit = 1'b1;
        hit_idx  = scan_idx;
        pops     = CW'(i + 1);
      end
    end
  end

  always_comb begin
    pend_reg_d = pend_reg_q;
    pend_vld_d = pend_vld_q;
    tail_d     = tail_q;
    busy_src   = BSRC_NONE;
    enq        = 1'b0;
    pop_n      = '0;
    write_d    = wb_fire;
    reg_wr_d   = wb_fire ? wb_reg : reg_wr_q;
    data_wr_d  = wb_fire ? wb_data : data_wr_q;

    if (Alloc_IN) begin
      busy_src = BSRC_ALLOC;
      enq      = wb_fire;
      for (int unsigned i = 0; i < PEND_DEPTH; i++) begin
        if (pend_reg_q[i] == AllocReg_IN) pend_vld_d[i] = 1'b0;
      end
    end else if (pend_hit) begin
      busy_src = BSRC_PEND;
      pop_n    = pops;
      enq      = wb_fire;
    end else begin
      pop_n = cnt_q;
      if (wb_fire) busy_src = BSRC_DIRECT;
    end

    set_busy_d = 1'b1;
    busy_val_d = BUSY_CLR;
    busy_reg_d = busy_reg_q;
    case (busy_src)
      BSRC_ALLOC: begin
        busy_val_d = BUSY_SET;
        busy_reg_d = AllocReg_IN;
      end
      BSRC_PEND:   busy_reg_d = pend_reg_q[hit_idx];
      BSRC_DIRECT: busy_reg_d = wb_reg;
      default: begin
        set_busy_d = 1'b0;
        busy_val_d = busy_val_q;
      end
    endcase

    head_d = (PEND_DEPTH == 1) ? '0 : head_q + PW'(pop_n);
    cnt_d  = cnt_q - pop_n;
    if (enq) begin
      pend_reg_d[tail_q] = wb_reg;
      pend_vld_d[tail_q] = 1'b1;
      tail_d             = (PEND_DEPTH == 1) ? '0 : tail_q + PW'(1);
      cnt_d              = cnt_d + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      write_q    <= 1'b0;
      reg_wr_q   <= '0;
      data_wr_q  <= '0;
      set_busy_q <= 1'b0;
      busy_val_q <= 1'b0;
      busy_reg_q <= '0;
      pend_vld_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      for (int unsigned i = 0; i < PEND_DEPTH; i++) pend_reg_q[i] <= '0;
    end else begin
      write_q    <= write_d;
      reg_wr_q   <= reg_wr_d;
      data_wr_q  <= data_wr_d;
      set_busy_q <= set_busy_d;
      busy_val_q <= busy_val_d;
      busy_reg_q <= busy_reg_d;
      pend_vld_q <= pend_vld_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      pend_reg_q <= pend_reg_d;
    end
  end

  assign Write_OUT     = write_q;
  assign RegWrite_OUT  = reg_wr_q;
  assign DataWrite_OUT = data_wr_q;
  assign SetBusy_OUT   = set_busy_q;
  assign BusyValue_OUT = busy_val_q;
  assign BusyReg_OUT   = busy_reg_q;

`ifdef WB_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q [NUM_REQ];
  logic [15:0] stall_cnt_d [NUM_REQ];

  always_comb begin
    StallCnt_OUT = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      stall_cnt_d[i] = stall_cnt_q[i];
      if (Req_IN[i] && !grant[i] && (stall_cnt_q[i] != 16'hFFFF))
        stall_cnt_d[i] = stall_cnt_q[i] + 16'd1;
      StallCnt_OUT[i*16 +: 16] = stall_cnt_q[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) stall_cnt_q[i] <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end
`endif

endmodule
